// File: rtl/serial_loader.sv
// serial_loader: turns a UART byte stream into RAM writes and a CPU start pulse.
// A LOAD frame ('L', addr_hi, addr_lo, count, data..., check) writes the data bytes
// to consecutive addresses.
// A GO frame ('G', addr_hi, addr_lo) releases the CPU at that address.
//
//   state  | meaning
//   IDLE   | waiting for a command byte, other bytes ignored
//   L_AHI  | LOAD: expecting start address high byte
//   L_ALO  | LOAD: expecting start address low byte
//   L_CNT  | LOAD: expecting byte count (0 = 256)
//   L_DATA | LOAD: each byte is written to RAM at ptr, ptr increments
//   L_CHK  | LOAD: expecting check byte, frame sum must be 0 mod 256
//   G_AHI  | GO: expecting start address high byte
//   G_ALO  | GO: expecting start address low byte, then pulse go

module serial_loader #(
    parameter logic [7:0] CMD_LOAD   = 8'h4C,
    parameter logic [7:0] CMD_GO     = 8'h47,
    parameter int         ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_en,
    output logic [7:0]            mem_data,
    output logic                  cpu_hold,
    output logic                  go,
    output logic [ADDR_WIDTH-1:0] go_address,
    output logic                  checksum_err
);

    typedef enum logic [2:0] {
        IDLE,
        L_AHI,
        L_ALO,
        L_CNT,
        L_DATA,
        L_CHK,
        G_AHI,
        G_ALO
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            count;
    logic [7:0]            sum;

    // Frame parser: every output is registered; strobes default low each cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            count        <= 8'd0;
            sum          <= 8'd0;
            mem_address  <= '0;
            mem_write_en <= 1'b0;
            mem_data     <= 8'd0;
            cpu_hold     <= 1'b1;
            go           <= 1'b0;
            go_address   <= '0;
            checksum_err <= 1'b0;
        end else begin
            mem_write_en <= 1'b0;
            go           <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_data == CMD_LOAD) begin
                            state        <= L_AHI;
                            cpu_hold     <= 1'b1;
                            checksum_err <= 1'b0;
                            sum          <= 8'd0;
                        end else if (rx_data == CMD_GO) begin
                            state <= G_AHI;
                        end
                    end
                    L_AHI: begin
                        ptr[15:8] <= rx_data;
                        sum       <= sum + rx_data;
                        state     <= L_ALO;
                    end
                    L_ALO: begin
                        ptr[7:0] <= rx_data;
                        sum      <= sum + rx_data;
                        state    <= L_CNT;
                    end
                    L_CNT: begin
                        // count runs down modulo 256, so a load of 0 yields 256 bytes
                        count <= rx_data;
                        sum   <= sum + rx_data;
                        state <= L_DATA;
                    end
                    L_DATA: begin
                        mem_address  <= ptr;
                        mem_data     <= rx_data;
                        mem_write_en <= 1'b1;
                        ptr          <= ptr + 1'b1;
                        sum          <= sum + rx_data;
                        count        <= count - 8'd1;
                        if (count == 8'd1) begin
                            state <= L_CHK;
                        end
                    end
                    L_CHK: begin
                        if ((sum + rx_data) != 8'd0) begin
                            checksum_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    G_AHI: begin
                        go_address[15:8] <= rx_data;
                        state            <= G_ALO;
                    end
                    G_ALO: begin
                        go_address[7:0] <= rx_data;
                        go              <= 1'b1;
                        cpu_hold        <= 1'b0;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: LOAD frames (normal, bad check, address wrap,
// 256-byte count), GO with leading junk, and asynchronous reset mid-frame.

module tb_serial_loader;

    logic        clock;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] mem_address;
    logic        mem_write_en;
    logic [7:0]  mem_data;
    logic        cpu_hold;
    logic        go;
    logic [15:0] go_address;
    logic        checksum_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] tb_data [256];

    serial_loader dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data     (mem_data),
        .cpu_hold     (cpu_hold),
        .go           (go),
        .go_address   (go_address),
        .checksum_err (checksum_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one rising edge, return at the following falling edge.
    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " mem_address"},  mem_address, 16'h0000);
        check({tag, " mem_write_en"}, mem_write_en, 1'b0);
        check({tag, " mem_data"},     mem_data, 8'h00);
        check({tag, " cpu_hold"},     cpu_hold, 1'b1);
        check({tag, " go"},           go, 1'b0);
        check({tag, " go_address"},   go_address, 16'h0000);
        check({tag, " checksum_err"}, checksum_err, 1'b0);
    endtask

    // Full LOAD frame using tb_data[0..n-1], checking each write one cycle after its byte.
    task automatic send_load(input string tag, input logic [15:0] addr, input int n,
                             input logic [7:0] chk_byte, input logic exp_err);
        logic [15:0] a;
        logic [7:0]  cnt;
        cnt = n[7:0];
        drive(8'h4C);
        check({tag, " cmd no write"}, mem_write_en, 1'b0);
        check({tag, " err cleared"}, checksum_err, 1'b0);
        check({tag, " hold on load"}, cpu_hold, 1'b1);
        drive(addr[15:8]);
        drive(addr[7:0]);
        drive(cnt);
        check({tag, " hdr no write"}, mem_write_en, 1'b0);
        a = addr;
        for (int i = 0; i < n; i++) begin
            drive(tb_data[i]);
            check({tag, " we"},   mem_write_en, 1'b1);
            check({tag, " addr"}, mem_address, a);
            check({tag, " data"}, mem_data, tb_data[i]);
            a = a + 16'd1;
        end
        drive(chk_byte);
        check({tag, " chk no write"}, mem_write_en, 1'b0);
        check({tag, " checksum_err"}, checksum_err, exp_err);
        check({tag, " cpu_hold"}, cpu_hold, 1'b1);
        idle_cycle();
        check({tag, " idle no write"}, mem_write_en, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_values("after reset");

        // 1: 00+10+03+AA+BB+CC = 0x244, check byte BC brings the sum to 0x300
        tb_data[0] = 8'hAA; tb_data[1] = 8'hBB; tb_data[2] = 8'hCC;
        send_load("t1", 16'h0010, 3, 8'hBC, 1'b0);

        // 2: same frame with check byte 00 -> sum 0x44, error but writes still happen
        send_load("t2", 16'h0010, 3, 8'h00, 1'b1);

        // 3: wrap FFFF -> 0000; FF+FF+02+11+22+CD = 0x300; its 4C also clears t2's error
        tb_data[0] = 8'h11; tb_data[1] = 8'h22;
        send_load("t3", 16'hFFFF, 2, 8'hCD, 1'b0);

        // 4: count 0 = 256 bytes 00..FF, data sum 0x7F80, check 80
        for (int i = 0; i < 256; i++) tb_data[i] = 8'(i);
        send_load("t4", 16'h0000, 256, 8'h80, 1'b0);
        check("t4 last addr", mem_address, 16'h00FF);

        // 5: junk byte then GO 0x1234
        drive(8'h55);
        check("t5 junk go", go, 1'b0);
        drive(8'h47);
        drive(8'h12);
        check("t5 go early", go, 1'b0);
        check("t5 hold before", cpu_hold, 1'b1);
        drive(8'h34);
        check("t5 go", go, 1'b1);
        check("t5 go_address", go_address, 16'h1234);
        check("t5 hold released", cpu_hold, 1'b0);
        check("t5 no write", mem_write_en, 1'b0);
        idle_cycle();
        check("t5 go one cycle", go, 1'b0);
        check("t5 hold stays low", cpu_hold, 1'b0);
        check("t5 go_address held", go_address, 16'h1234);

        // 6: reset mid L_DATA after one of three bytes, between clock edges
        tb_data[0] = 8'h5A;
        drive(8'h4C);
        check("t6 hold on load", cpu_hold, 1'b1);
        drive(8'h00);
        drive(8'h20);
        drive(8'h03);
        drive(tb_data[0]);
        check("t6 first write we", mem_write_en, 1'b1);
        check("t6 first write addr", mem_address, 16'h0020);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6 async");
        @(negedge clock);
        reset = 1'b0;
        drive(8'h47);
        check("t6 no stray write a", mem_write_en, 1'b0);
        drive(8'h00);
        check("t6 no stray write b", mem_write_en, 1'b0);
        drive(8'h00);
        check("t6 go", go, 1'b1);
        check("t6 go_address", go_address, 16'h0000);
        check("t6 hold released", cpu_hold, 1'b0);
        check("t6 no stray write c", mem_write_en, 1'b0);
        idle_cycle();
        check("t6 go one cycle", go, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
